// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage slice.
//   skid_state_e : occupancy state of the skid stage (EMPTY/HALF/FULL)
//   NOP_WORD     : the all-zero word driven on the data outputs as a bubble.
//                  Narrow it to the target width with a size cast.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // nothing held
    ST_HALF  = 2'd1,  // output register holds one beat
    ST_FULL  = 2'd2   // output register and skid register both hold beats
  } skid_state_e;

  localparam int unsigned      MAX_WORD_W = 64;
  localparam logic [MAX_WORD_W-1:0] NOP_WORD = '0;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Performance counters for the skid stage output port.
//   clk, rst   : clock and synchronous active-high reset (clears both counters)
//   dn_valid   : downstream beat present
//   dn_ready   : downstream accepts the beat
//   stall_cnt  : cycles with a beat present but not accepted
//   bubble_cnt : cycles with no beat present (reset cycles are excluded)
// Both counters wrap modulo 2^CNT_W. Flush does not touch them.
module pipe_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dn_valid,
  input  logic             dn_ready,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (dn_valid && !dn_ready) stall_cnt  <= stall_cnt + CNT_W'(1);
      if (!dn_valid)             bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Fully registered pipeline stage with a one-entry skid buffer, carrying an
// instruction address/word pair.
//   clk, rst              : clock, synchronous active-high reset
//   flush                 : drop every held and incoming beat on the next edge
//   up_valid/up_ready     : upstream handshake (up_ready is a flop output)
//   up_pc/up_inst         : upstream beat
//   dn_valid/dn_ready     : downstream handshake
//   dn_pc/dn_inst         : downstream beat, all-zero when dn_valid=0
//   stall_cnt/bubble_cnt  : perf counters
// Config macro PIPE_STAGE_PERF_CNT_EN: when defined, pipe_perf_cnt drives the
// counters; otherwise the counter ports are tied to zero.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int INST_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [PC_W-1:0]   up_pc,
  input  logic [INST_W-1:0] up_inst,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [PC_W-1:0]   dn_pc,
  output logic [INST_W-1:0] dn_inst,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  skid_state_e       state, nstate;
  logic [PC_W-1:0]   out_pc, skid_pc;
  logic [INST_W-1:0] out_inst, skid_inst;

  logic xfer_in, xfer_out;
  logic load_out_up, load_out_skid, clr_out, load_skid, clr_skid;

  assign dn_valid = (state != ST_EMPTY);
  assign dn_pc    = out_pc;
  assign dn_inst  = out_inst;

  assign xfer_in  = up_valid & up_ready;
  assign xfer_out = dn_valid & dn_ready;

  always_comb begin
    nstate        = state;
    load_out_up   = 1'b0;
    load_out_skid = 1'b0;
    clr_out       = 1'b0;
    load_skid     = 1'b0;
    clr_skid      = 1'b0;
    unique case (state)
      ST_EMPTY: begin
        if (xfer_in) begin
          nstate      = ST_HALF;
          load_out_up = 1'b1;
        end
      end
      ST_HALF: begin
        if (xfer_in && xfer_out) begin
          load_out_up = 1'b1;
        end else if (xfer_in) begin
          nstate    = ST_FULL;
          load_skid = 1'b1;
        end else if (xfer_out) begin
          nstate  = ST_EMPTY;
          clr_out = 1'b1;   // keep the bubble a zero word
        end
      end
      ST_FULL: begin
        // up_ready is low here, so only the drain side can move.
        if (xfer_out) begin
          nstate        = ST_HALF;
          load_out_skid = 1'b1;
          clr_skid      = 1'b1;
        end
      end
      default: nstate = ST_EMPTY;
    endcase
  end

  // Reset and flush produce the same state; reset simply wins the priority.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state     <= ST_EMPTY;
      up_ready  <= 1'b1;
      out_pc    <= PC_W'(NOP_WORD);
      out_inst  <= INST_W'(NOP_WORD);
      skid_pc   <= PC_W'(NOP_WORD);
      skid_inst <= INST_W'(NOP_WORD);
    end else begin
      state    <= nstate;
      // Registered from next state, so there is no dn_ready -> up_ready path.
      up_ready <= (nstate != ST_FULL);
      if (load_out_up) begin
        out_pc   <= up_pc;
        out_inst <= up_inst;
      end else if (load_out_skid) begin
        out_pc   <= skid_pc;
        out_inst <= skid_inst;
      end else if (clr_out) begin
        out_pc   <= PC_W'(NOP_WORD);
        out_inst <= INST_W'(NOP_WORD);
      end
      if (load_skid) begin
        skid_pc   <= up_pc;
        skid_inst <= up_inst;
      end else if (clr_skid) begin
        skid_pc   <= PC_W'(NOP_WORD);
        skid_inst <= INST_W'(NOP_WORD);
      end
    end
  end

`ifdef PIPE_STAGE_PERF_CNT_EN
  pipe_perf_cnt #(.CNT_W(CNT_W)) u_perf (
    .clk        (clk),
    .rst        (rst),
    .dn_valid   (dn_valid),
    .dn_ready   (dn_ready),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter PC_W, default 32, width of the carried instruction address.
REQ-002 Parameter INST_W, default 32, width of the carried instruction word.
REQ-003 Parameter CNT_W, default 32, width of each performance counter.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset rst, synchronous, active-high; clock clk.
REQ-006 flush  input  1  discard all held and incoming beats (branch/exception redirect).
REQ-007 up_valid  input  1  upstream beat present.
REQ-008 up_ready  output  1  stage can accept a beat; registered, no combinational path from dn_ready.
REQ-009 up_pc  input  PC_W  upstream instruction address.
REQ-010 up_inst  input  INST_W  upstream instruction word.
REQ-011 dn_valid  output  1  downstream beat present.
REQ-012 dn_ready  input  1  downstream accepts the beat.
REQ-013 dn_pc  output  PC_W  downstream instruction address.
REQ-014 dn_inst  output  INST_W  downstream instruction word.
REQ-015 stall_cnt  output  CNT_W  cycles with dn_valid=1 and dn_ready=0.
REQ-016 bubble_cnt  output  CNT_W  cycles with dn_valid=0 and not in reset.

Function
REQ-017 Transfer in = up_valid & up_ready; transfer out = dn_valid & dn_ready; both in one cycle SHALL be legal.
REQ-018 States: EMPTY (no beat), HALF (output register holds one beat), FULL (output register plus skid register hold beats).
REQ-019 EMPTY: transfer in -> HALF, beat loaded into output register; latency in-to-out exactly 1 cycle.
REQ-020 HALF: in only -> FULL, beat into skid; out only -> EMPTY; in and out -> HALF, new beat into output register.
REQ-021 FULL: out -> HALF, skid beat moves to output register; up_ready SHALL be 0 in FULL, so no transfer in.
REQ-022 up_ready SHALL equal (state != FULL) as a registered signal.
REQ-023 Beats SHALL leave in arrival order; no beat duplicated or dropped except by flush.
REQ-024 dn_valid SHALL be 1 in HALF and FULL, 0 in EMPTY.
REQ-025 dn_pc and dn_inst SHALL be all-zero whenever dn_valid=0 (bubble = zero word, a NOP).
REQ-026 flush SHALL, on the next edge, force EMPTY, zero both registers, discard any beat accepted in the flush cycle.
REQ-027 flush and rst together: rst takes priority; resulting state identical.
REQ-028 Counters SHALL wrap modulo 2^CNT_W; flush SHALL not clear them.

Reset
REQ-029 On rst: state EMPTY, up_ready=1 after the edge, dn_valid=0, dn_pc=0, dn_inst=0, skid register=0, stall_cnt=0, bubble_cnt=0.
REQ-030 rst mid-transfer SHALL discard all held beats with no beat emitted in the reset cycle.

Configuration
REQ-031 Macro PIPE_STAGE_PERF_CNT_EN defined: stall_cnt and bubble_cnt count per REQ-015/016.
REQ-032 Macro undefined: counter logic absent, stall_cnt and bubble_cnt SHALL be constant zero; ports remain.

Structure
REQ-033 State encoding (EMPTY/HALF/FULL) and the zero-word constant SHALL reside in the shared package pipe_pkg.
REQ-034 Counters SHALL be one sub-module, pipe_perf_cnt, instantiated only when PIPE_STAGE_PERF_CNT_EN is defined.
REQ-035 Skid/state control SHALL remain in pipe_stage_skid; no further sub-modules.

Verification
REQ-036 Reset, then up_valid=1, up_pc=0x0000_1000, up_inst=0x2402_0005, dn_ready=1 -> next cycle dn_valid=1, dn_pc=0x0000_1000, dn_inst=0x2402_0005.
REQ-037 dn_ready=0, push beats A(pc 0x10), B(pc 0x14) -> FULL, up_ready=0; C held upstream; dn_ready=1 -> A, B, C in order, no loss.
REQ-038 FULL, then flush=1 with up_valid=1 -> next cycle dn_valid=0, dn_pc=0, dn_inst=0, up_ready=1; flushed beat never appears.
REQ-039 Continuous up_valid=1, dn_ready=1 for 100 beats -> one beat per cycle, stall_cnt=0, state HALF throughout.
REQ-040 With macro, CNT_W=4, dn_ready=0 with valid beat for 17 cycles -> stall_cnt=1 (wrap); without macro -> stall_cnt=0.
REQ-041 rst asserted while FULL -> next cycle dn_valid=0, up_ready=1, counters 0.
